// File: rtl/audio_nios_timer_host.sv
// -----------------------------------------------------------------------------
// audio_nios_timer_host
//
// Avalon-MM initiator that runs the audio subsystem's 16-bit interval timer
// (s1 port: no waitrequest, registered readdata, 1-cycle read latency) on
// behalf of the audio datapath. It programs the period, starts the timer in
// one-shot or continuous mode, clears status on every irq, counts timeouts
// and emits a one-cycle tick per serviced timeout.
//
// Optional feature: define AUDIO_TIMER_HOST_SNAPSHOT_EN to capture the timer
// counter snapshot after every serviced timeout (SNAP_* states replace GUARD).
// Without it, snapshot is tied to 0.
//
// Parameters:
//   TICK_W     width of tick_count
//   MAX_TICKS  continuous mode auto-stop after this many ticks (0 = unlimited)
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start, stop       control pulses from the audio datapath
//   period_in         32-bit period (one timeout every period_in+1 clocks)
//   continuous        1 = continuous, 0 = one-shot
//   m_*               Avalon-MM master towards the timer s1 port
//   irq               timer interrupt (level)
//   busy              high in every state except IDLE
//   tick              one-cycle pulse per serviced timeout
//   tick_count        timeouts serviced since last start (wraps)
//   snapshot          last captured counter snapshot
// -----------------------------------------------------------------------------
module audio_nios_timer_host #(
    parameter int TICK_W    = 16,
    parameter int MAX_TICKS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       period_in,
    input  logic              continuous,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [15:0]       m_writedata,
    input  logic [15:0]       m_readdata,
    input  logic              irq,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snapshot
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTL,
        WAIT_IRQ,
        CLR_ST,
        GUARD,
        WR_STOP,
        SNAP_WR,
        SNAP_RL,
        SNAP_RH,
        SNAP_CAP
    } state_t;

    // Timer register map (word addresses).
    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_PERL   = 3'd2;
    localparam logic [2:0] A_PERH   = 3'd3;
    localparam logic [2:0] A_SNAPL  = 3'd4;
    localparam logic [2:0] A_SNAPH  = 3'd5;

    // Control register values: ITO=bit0, CONT=bit1, START=bit2, STOP=bit3.
    localparam logic [15:0] CTL_START = 16'h0005;
    localparam logic [15:0] CTL_STOP  = 16'h0008;

    state_t      state;
    state_t      next_state;
    logic [15:0] period_hi_q;
    logic        cont_q;
    logic        stop_pending;
    logic        max_hit;

    // Next values of the registered bus outputs.
    logic [2:0]  nx_address;
    logic        nx_chipselect;
    logic        nx_write_n;
    logic [15:0] nx_writedata;

    // tick_count already holds the incremented value while in CLR_ST.
    assign max_hit = (MAX_TICKS != 0) && (tick_count == TICK_W'(MAX_TICKS));
    assign busy    = (state != IDLE);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = WR_PL;
            WR_PL:    next_state = WR_PH;
            WR_PH:    next_state = WR_CTL;
            WR_CTL:   next_state = WAIT_IRQ;
            WAIT_IRQ: begin
                // Stop wins over an irq seen in the same cycle.
                if (stop_pending || stop) next_state = WR_STOP;
                else if (irq)             next_state = CLR_ST;
            end
            CLR_ST: begin
                if (!cont_q || max_hit) next_state = WR_STOP;
`ifdef AUDIO_TIMER_HOST_SNAPSHOT_EN
                else                    next_state = SNAP_WR;
`else
                else                    next_state = GUARD;
`endif
            end
            // irq is still high here (status clear just landed); skip it.
            GUARD:    next_state = WAIT_IRQ;
            WR_STOP:  next_state = IDLE;
`ifdef AUDIO_TIMER_HOST_SNAPSHOT_EN
            SNAP_WR:  next_state = SNAP_RL;
            SNAP_RL:  next_state = SNAP_RH;
            SNAP_RH:  next_state = SNAP_CAP;
            SNAP_CAP: next_state = WAIT_IRQ;
`endif
            default:  next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: bus values are decoded from next_state and registered, so
    // each access is presented for exactly the cycle spent in its state.
    // -------------------------------------------------------------------------
    always_comb begin
        nx_address    = 3'd0;
        nx_chipselect = 1'b0;
        nx_write_n    = 1'b1;
        nx_writedata  = 16'h0000;
        case (next_state)
            WR_PL: begin
                // Only reachable from IDLE, so period_in is still the fresh value.
                nx_chipselect = 1'b1;
                nx_write_n    = 1'b0;
                nx_address    = A_PERL;
                nx_writedata  = period_in[15:0];
            end
            WR_PH: begin
                nx_chipselect = 1'b1;
                nx_write_n    = 1'b0;
                nx_address    = A_PERH;
                nx_writedata  = period_hi_q;
            end
            WR_CTL: begin
                nx_chipselect = 1'b1;
                nx_write_n    = 1'b0;
                nx_address    = A_CTRL;
                nx_writedata  = CTL_START | {14'd0, cont_q, 1'b0};
            end
            CLR_ST: begin
                nx_chipselect = 1'b1;
                nx_write_n    = 1'b0;
                nx_address    = A_STATUS;
            end
            WR_STOP: begin
                nx_chipselect = 1'b1;
                nx_write_n    = 1'b0;
                nx_address    = A_CTRL;
                nx_writedata  = CTL_STOP;
            end
`ifdef AUDIO_TIMER_HOST_SNAPSHOT_EN
            SNAP_WR: begin
                nx_chipselect = 1'b1;
                nx_write_n    = 1'b0;
                nx_address    = A_SNAPL;
            end
            SNAP_RL: begin
                nx_chipselect = 1'b1;
                nx_address    = A_SNAPL;
            end
            SNAP_RH: begin
                nx_chipselect = 1'b1;
                nx_address    = A_SNAPH;
            end
`endif
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state        <= IDLE;
            m_address    <= 3'd0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= 16'h0000;
            tick         <= 1'b0;
            tick_count   <= '0;
            period_hi_q  <= 16'h0000;
            cont_q       <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            state        <= next_state;
            m_address    <= nx_address;
            m_chipselect <= nx_chipselect;
            m_write_n    <= nx_write_n;
            m_writedata  <= nx_writedata;
            tick         <= (next_state == CLR_ST);

            if (state == IDLE && start) begin
                period_hi_q <= period_in[31:16];
                cont_q      <= continuous;
                tick_count  <= '0;
            end else if (next_state == CLR_ST) begin
                tick_count  <= tick_count + TICK_W'(1);
            end

            // Stop outside WAIT_IRQ is parked until the next WAIT_IRQ entry.
            if (state == WR_STOP)
                stop_pending <= 1'b0;
            else if (stop && state != IDLE && state != WAIT_IRQ)
                stop_pending <= 1'b1;
        end
    end

`ifdef AUDIO_TIMER_HOST_SNAPSHOT_EN
    // readdata is valid one cycle after the address: low half arrives while
    // SNAP_RH presents the high address, high half arrives in SNAP_CAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot <= 32'h0000_0000;
        end else if (state == SNAP_RH) begin
            snapshot[15:0] <= m_readdata;
        end else if (state == SNAP_CAP) begin
            snapshot[31:16] <= m_readdata;
        end
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^m_readdata;
    assign snapshot        = 32'h0000_0000;
`endif

endmodule
